// File: rtl/stack_seq.sv
// 6502 stack push/pull sequencer: drives page-1 memory strobes for multi-byte
// stack commands and writes the final SP back once. Optional macro: STACK_SEQ_OVF_DET_EN.
module stack_seq #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic        RDY,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd,
  output logic        ready,
  input  logic [7:0]  sp_q,
  input  logic [7:0]  a_in,
  input  logic [7:0]  p_in,
  input  logic [15:0] pc_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        sp_en,
  output logic [7:0]  sp_d,
  output logic        done,
  output logic [7:0]  pul_a,
  output logic [7:0]  pul_p,
  output logic [15:0] pul_pc,
  output logic        ovf
);

  localparam logic [3:0] C_PHA   = 4'd1;
  localparam logic [3:0] C_PHP   = 4'd2;
  localparam logic [3:0] C_PLA   = 4'd3;
  localparam logic [3:0] C_PLP   = 4'd4;
  localparam logic [3:0] C_PSHPC = 4'd5;
  localparam logic [3:0] C_PULPC = 4'd6;
  localparam logic [3:0] C_INTR  = 4'd7;
  localparam logic [3:0] C_RTI   = 4'd8;

  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_PULL_RD, S_PULL_CAP, S_DONE} state_t;
  typedef enum logic [1:0] {D_A, D_P, D_PCL, D_PCH} dest_t;

  state_t           r_state, w_next;
  logic [7:0]       r_ptr;
  logic [1:0]       r_idx, r_last;
  logic [3:0]       r_kind;
  logic [3:0][7:0]  r_buf;
  logic [15:0]      r_addr;
  logic [7:0]       r_wdata;
  logic [7:0]       r_pul_a, r_pul_p;
  logic [15:0]      r_pul_pc;

  logic             w_legal, w_push, w_acc, w_last_byte;
  logic [1:0]       w_last;
  logic [3:0][7:0]  w_buf;
  logic [7:0]       w_ptr_inc;
  dest_t            w_dest;

  assign w_ptr_inc   = r_ptr + 8'd1;
  assign w_acc       = (r_state == S_IDLE) & RDY & cmd_valid & w_legal;
  assign w_last_byte = (r_idx == r_last);

  // Command decode: push bytes are queued in the order they hit memory.
  always_comb begin
    w_legal = 1'b1;
    w_push  = 1'b0;
    w_last  = 2'd0;
    w_buf   = '0;
    case (cmd)
      C_PHA:   begin w_push = 1'b1; w_buf[0] = a_in; end
      C_PHP:   begin w_push = 1'b1; w_buf[0] = p_in; end
      C_PLA, C_PLP: ;
      C_PSHPC: begin
        w_push = 1'b1; w_last = 2'd1;
        w_buf[0] = pc_in[15:8]; w_buf[1] = pc_in[7:0];
      end
      C_PULPC: w_last = 2'd1;
      C_INTR:  begin
        w_push = 1'b1; w_last = 2'd2;
        w_buf[0] = pc_in[15:8]; w_buf[1] = pc_in[7:0]; w_buf[2] = p_in;
      end
      C_RTI:   w_last = 2'd2;
      default: w_legal = 1'b0;
    endcase
  end

  // Destination of the byte being captured, by command and byte index.
  always_comb begin
    w_dest = D_A;
    case (r_kind)
      C_PLP:   w_dest = D_P;
      C_PULPC: w_dest = (r_idx == 2'd0) ? D_PCL : D_PCH;
      C_RTI:   w_dest = (r_idx == 2'd0) ? D_P : (r_idx == 2'd1) ? D_PCL : D_PCH;
      default: w_dest = D_A;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_acc) w_next = w_push ? S_PUSH : S_PULL_RD;
      S_PUSH:     if (w_last_byte) w_next = S_DONE;
      S_PULL_RD:  w_next = S_PULL_CAP;
      S_PULL_CAP: w_next = w_last_byte ? S_DONE : S_PULL_RD;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (!RDY) w_next = r_state;
  end

  // Address/data follow the live pointer while strobing and hold the last value otherwise.
  always_comb begin
    ready     = (r_state == S_IDLE);
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    sp_en     = 1'b0;
    done      = 1'b0;
    sp_d      = '0;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    case (r_state)
      S_PUSH: begin
        mem_we    = RDY;
        mem_addr  = {STACK_PAGE, r_ptr};
        mem_wdata = r_buf[r_idx];
      end
      S_PULL_RD: begin
        mem_re   = RDY;
        mem_addr = {STACK_PAGE, w_ptr_inc};
      end
      S_DONE: begin
        sp_en = RDY;
        done  = RDY;
        sp_d  = r_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_last   <= '0;
      r_kind   <= '0;
      r_buf    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_pul_a  <= '0;
      r_pul_p  <= '0;
      r_pul_pc <= '0;
    end else begin
      r_state <= w_next;
      if (RDY) begin
        case (r_state)
          S_IDLE: if (w_acc) begin
            r_ptr  <= sp_q;
            r_idx  <= 2'd0;
            r_last <= w_last;
            r_kind <= cmd;
            r_buf  <= w_buf;
          end
          S_PUSH: begin
            r_addr  <= {STACK_PAGE, r_ptr};
            r_wdata <= r_buf[r_idx];
            r_ptr   <= r_ptr - 8'd1;
            r_idx   <= r_idx + 2'd1;
          end
          S_PULL_RD: begin
            r_addr <= {STACK_PAGE, w_ptr_inc};
            r_ptr  <= w_ptr_inc;
          end
          S_PULL_CAP: begin
            r_idx <= r_idx + 2'd1;
            case (w_dest)
              D_A:     r_pul_a        <= mem_rdata;
              D_P:     r_pul_p        <= mem_rdata;
              D_PCL:   r_pul_pc[7:0]  <= mem_rdata;
              default: r_pul_pc[15:8] <= mem_rdata;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign pul_a  = r_pul_a;
  assign pul_p  = r_pul_p;
  assign pul_pc = r_pul_pc;

`ifdef STACK_SEQ_OVF_DET_EN
  logic r_ovf;
  // Sticky wrap flag; a fresh command strobe in IDLE clears it.
  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (RDY) begin
      if (r_state == S_IDLE && cmd_valid && r_ovf)
        r_ovf <= 1'b0;
      else if ((r_state == S_PUSH && r_ptr == 8'h00) ||
               (r_state == S_PULL_RD && r_ptr == 8'hFF))
        r_ovf <= 1'b1;
    end
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: transaction-level stack model plus directed and random command streams.
module tb_stack_seq;

`ifdef STACK_SEQ_OVF_DET_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk2 = 1'b0, rst = 1'b0, RDY = 1'b1, cmd_valid = 1'b0;
  logic [3:0]  cmd = '0;
  logic [7:0]  sp_q = '0, a_in = '0, p_in = '0;
  logic [15:0] pc_in = '0;
  logic [7:0]  mem_rdata = '0;
  logic        ready, mem_we, mem_re, sp_en, done, ovf;
  logic [15:0] mem_addr, pul_pc;
  logic [7:0]  mem_wdata, sp_d, pul_a, pul_p;

  stack_seq #(.STACK_PAGE(8'h01)) dut (
    .clk2(clk2), .rst(rst), .RDY(RDY), .cmd_valid(cmd_valid), .cmd(cmd), .ready(ready),
    .sp_q(sp_q), .a_in(a_in), .p_in(p_in), .pc_in(pc_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .sp_en(sp_en), .sp_d(sp_d), .done(done),
    .pul_a(pul_a), .pul_p(pul_p), .pul_pc(pul_pc), .ovf(ovf)
  );

  always #5 clk2 = ~clk2;

  // Page-1 RAM seen by the DUT; read data appears the cycle after mem_re.
  logic [7:0] dmem [256];
  always @(posedge clk2) begin
    if (mem_we) dmem[mem_addr[7:0]] = mem_wdata;
    if (mem_re) mem_rdata <= dmem[mem_addr[7:0]];
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic we; logic [15:0] addr; logic [7:0] data; } op_t;
  op_t         q[$];
  logic [7:0]  rmem [256];
  bit          m_busy = 0, m_ovf = 0, m_wrap = 0;
  int          m_cyc, m_stall, m_lat;
  logic [7:0]  m_sp, m_pa = 0, m_pp = 0, ex_pa, ex_pp;
  logic [15:0] m_ppc = 0, ex_ppc;
  logic [15:0] wa[4], ra[4];
  logic [7:0]  wd[4], last_sp;
  int          nw, nr, last_lat, n_done = 0;

  task automatic m_start();
    logic [7:0] pb[$];
    int         dst[$];
    logic [7:0] p, v;
    op_t        op;
    p = sp_q; pb.delete(); dst.delete();
    case (cmd)
      4'd1: pb.push_back(a_in);
      4'd2: pb.push_back(p_in);
      4'd3: dst.push_back(0);
      4'd4: dst.push_back(1);
      4'd5: begin pb.push_back(pc_in[15:8]); pb.push_back(pc_in[7:0]); end
      4'd6: begin dst.push_back(2); dst.push_back(3); end
      4'd7: begin pb.push_back(pc_in[15:8]); pb.push_back(pc_in[7:0]); pb.push_back(p_in); end
      4'd8: begin dst.push_back(1); dst.push_back(2); dst.push_back(3); end
      default: return;
    endcase
    q.delete(); m_wrap = 0; nw = 0; nr = 0; m_cyc = 0; m_stall = 0; m_busy = 1;
    ex_pa = m_pa; ex_pp = m_pp; ex_ppc = m_ppc;
    foreach (pb[i]) begin
      op.we = 1'b1; op.addr = {8'h01, p}; op.data = pb[i]; q.push_back(op);
      if (p == 8'h00) m_wrap = 1;
      p = p - 8'd1;
    end
    foreach (dst[i]) begin
      if (p == 8'hFF) m_wrap = 1;
      p = p + 8'd1;
      op.we = 1'b0; op.addr = {8'h01, p}; op.data = 8'h00; q.push_back(op);
      v = rmem[p];
      case (dst[i])
        0: ex_pa = v;
        1: ex_pp = v;
        2: ex_ppc[7:0] = v;
        default: ex_ppc[15:8] = v;
      endcase
    end
    m_lat = (pb.size() > 0) ? pb.size() + 1 : 2 * dst.size() + 1;
    m_sp  = p;
  endtask

  // Single compare process, mid-cycle.
  always @(negedge clk2) begin
    op_t op;
    bit  exp_done;
    if (!rst) begin
      q.delete(); m_busy = 0; m_ovf = 0; m_pa = 0; m_pp = 0; m_ppc = 0;
    end else begin
      chk("sp_en_vs_done", sp_en, done);
      chk("ready", ready, !m_busy);
      if (!RDY) chk("stall_strobes", {mem_we, mem_re, sp_en, done}, 4'b0);
      if (mem_we) begin
        if (q.size() == 0) chk("unexpected_we", mem_addr, 32'hFFFF_FFFF);
        else begin
          op = q.pop_front();
          chk("wr_kind", 1'b1, op.we);
          chk("wr_addr", mem_addr, op.addr);
          chk("wr_data", mem_wdata, op.data);
          rmem[op.addr[7:0]] = op.data;
          if (nw < 4) begin wa[nw] = mem_addr; wd[nw] = mem_wdata; end
          nw++;
        end
      end
      if (mem_re) begin
        if (q.size() == 0) chk("unexpected_re", mem_addr, 32'hFFFF_FFFF);
        else begin
          op = q.pop_front();
          chk("rd_kind", 1'b0, op.we);
          chk("rd_addr", mem_addr, op.addr);
          if (nr < 4) ra[nr] = mem_addr;
          nr++;
        end
      end
      if (m_busy) begin
        m_cyc++;
        if (!RDY) m_stall++;
        exp_done = RDY && (m_cyc == m_lat + m_stall);
        chk("done", done, exp_done);
        if (exp_done) begin
          m_ovf = m_ovf | (m_wrap & OVF_EN);
          m_pa = ex_pa; m_pp = ex_pp; m_ppc = ex_ppc;
          chk("sp_d", sp_d, m_sp);
          chk("pul_a", pul_a, m_pa);
          chk("pul_p", pul_p, m_pp);
          chk("pul_pc", pul_pc, m_ppc);
          chk("ops_left", q.size(), 0);
          chk("done_ovf", ovf, m_ovf);
          last_sp = sp_d; last_lat = m_cyc; n_done++;
          m_busy = 0;
        end
      end else begin
        chk("idle_done", done, 1'b0);
        chk("idle_ovf", ovf, m_ovf);
        chk("idle_pul", {pul_a, pul_p, pul_pc}, {m_pa, m_pp, m_ppc});
        if (cmd_valid && RDY) begin
          m_ovf = 0;
          m_start();
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] c, input logic [7:0] sp, input logic [7:0] a,
                       input logic [7:0] p, input logic [15:0] pc);
    cmd = c; sp_q = sp; a_in = a; p_in = p; pc_in = pc; cmd_valid = 1'b1;
    @(posedge clk2); #1;
    cmd_valid = 1'b0;
    a_in = 8'($urandom); p_in = 8'($urandom); pc_in = 16'($urandom); sp_q = 8'($urandom);
  endtask

  task automatic wait_idle(input bit rnd);
    for (int i = 0; i < 200; i++) begin
      if (!m_busy) break;
      if (rnd) begin
        RDY = ($urandom_range(0, 3) != 0);
        cmd_valid = 1'($urandom); cmd = 4'($urandom);
        a_in = 8'($urandom); p_in = 8'($urandom); pc_in = 16'($urandom); sp_q = 8'($urandom);
      end
      @(posedge clk2); #1;
    end
    cmd_valid = 1'b0;
    chk("idle_timeout", m_busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    for (int i = 0; i < 256; i++) begin dmem[i] = 8'($urandom); rmem[i] = dmem[i]; end
    repeat (3) @(posedge clk2); #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_strobes", {mem_we, mem_re, sp_en, done, ovf}, 5'b0);
    chk("rst_addr_data", {mem_addr, mem_wdata, sp_d}, 32'h0);
    chk("rst_pul", {pul_a, pul_p, pul_pc}, 32'h0);
    rst = 1'b1;
    @(posedge clk2); #1;

    // 1: INTR from 0xFD
    issue(4'd7, 8'hFD, 8'h00, 8'h34, 16'h1234); wait_idle(0);
    chk("t1_w0", {wa[0], wd[0]}, {16'h01FD, 8'h12});
    chk("t1_w1", {wa[1], wd[1]}, {16'h01FC, 8'h34});
    chk("t1_w2", {wa[2], wd[2]}, {16'h01FB, 8'h34});
    chk("t1_sp", last_sp, 8'hFA);
    chk("t1_lat", last_lat, 4);

    // 2: RTI from 0xFA
    dmem[8'hFB] = 8'hA5; dmem[8'hFC] = 8'h78; dmem[8'hFD] = 8'h56;
    rmem[8'hFB] = 8'hA5; rmem[8'hFC] = 8'h78; rmem[8'hFD] = 8'h56;
    issue(4'd8, 8'hFA, 8'h00, 8'h00, 16'h0); wait_idle(0);
    chk("t2_pul_p", pul_p, 8'hA5);
    chk("t2_pul_pc", pul_pc, 16'h5678);
    chk("t2_sp", last_sp, 8'hFD);
    chk("t2_lat", last_lat, 7);

    // 3: PHA at SP=0x00 wraps
    issue(4'd1, 8'h00, 8'h9C, 8'h00, 16'h0); wait_idle(0);
    chk("t3_w0", {wa[0], wd[0]}, {16'h0100, 8'h9C});
    chk("t3_sp", last_sp, 8'hFF);
    chk("t3_ovf", ovf, OVF_EN);

    // 4: PULPC at SP=0xFF wraps into 0x0100
    issue(4'd6, 8'hFF, 8'h00, 8'h00, 16'h0); wait_idle(0);
    chk("t4_r0", ra[0], 16'h0100);
    chk("t4_r1", ra[1], 16'h0101);
    chk("t4_sp", last_sp, 8'h01);
    chk("t4_pcl", pul_pc[7:0], 8'h9C);

    // 5: PSHPC with RDY low three cycles after the first write
    issue(4'd5, 8'h40, 8'h00, 8'h00, 16'hBEEF);
    @(posedge clk2); #1; RDY = 1'b0;
    repeat (3) @(posedge clk2); #1; RDY = 1'b1;
    wait_idle(0);
    chk("t5_w0", {wa[0], wd[0]}, {16'h0140, 8'hBE});
    chk("t5_w1", {wa[1], wd[1]}, {16'h013F, 8'hEF});
    chk("t5_nw", nw, 2);
    chk("t5_sp", last_sp, 8'h3E);
    chk("t5_lat", last_lat, 6);

    // 6: reset during the second byte of INTR, cmd_valid held high meanwhile
    d0 = n_done;
    issue(4'd7, 8'h80, 8'h00, 8'h11, 16'hCAFE);
    cmd = 4'd1; cmd_valid = 1'b1;
    @(posedge clk2); #1;
    rst = 1'b0; #1;
    chk("t6_strobes", {mem_we, mem_re, sp_en, done}, 4'b0);
    chk("t6_addr", {mem_addr, mem_wdata}, 24'h0);
    chk("t6_ready", ready, 1'b1);
    chk("t6_pul", {pul_a, pul_p, pul_pc}, 32'h0);
    chk("t6_first_byte", dmem[8'h80], 8'hCA);
    cmd_valid = 1'b0;
    @(posedge clk2); #1; rst = 1'b1;
    @(posedge clk2); #1;
    chk("t6_no_done", n_done, d0);
    issue(4'd3, 8'hFA, 8'h00, 8'h00, 16'h0); wait_idle(0);
    chk("t6_pla", pul_a, 8'hA5);
    chk("t6_pla_sp", last_sp, 8'hFB);
    chk("t6_pla_lat", last_lat, 3);

    // Random command stream with stalls and noise on the inputs
    for (int it = 0; it < 250; it++) begin
      RDY = ($urandom_range(0, 4) != 0);
      issue(4'($urandom_range(0, 15)),
            ($urandom_range(0, 5) == 0) ? 8'h00 : ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom),
            8'($urandom), 8'($urandom), 16'($urandom));
      wait_idle(1);
      RDY = 1'b1;
    end
    repeat (2) @(posedge clk2); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
